// File: rtl/pci_target_data_phase.sv
// PCI target data-phase engine: captures the address-phase command and waits
// for the decoder's DEVSEL claim. It then drives DEVSEL#/TRDY# and runs single
// or burst transfers against a local DEPTH x 32-bit register file. A burst
// that runs past the last word is disconnected with STOP#. All state changes
// on the falling clock edge.
module pci_target_data_phase #(
    parameter logic [31:0] BASE_ADDR = 32'd1000,
    parameter int          DEPTH     = 16,
    parameter int          CLAIM_TO  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame,
    input  logic        irdy,
    input  logic [31:0] AD,
    input  logic [3:0]  cbe,
    input  logic        dec_devsel,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic        DEVSEL,
    output logic        TRDY,
    output logic        STOP
);

    localparam int             IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0]  IDX_LAST = IW'(DEPTH - 1);
    localparam int             CW       = (CLAIM_TO > 1) ? $clog2(CLAIM_TO) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLAIM_TO - 1);
    localparam logic [3:0]     CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0]     CMD_MEM_WRITE = 4'b0111;

    typedef enum logic [2:0] {
        IDLE,
        CLAIM,
        DATA,
        DISC,
        TURN
    } state_t;

    state_t         state, state_nxt;
    logic [31:0]    addr, addr_nxt;
    logic [3:0]     cmd, cmd_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [IW-1:0]  idx, idx_nxt, idx_inc;
    logic [31:0]    ad_out_nxt;
    logic           ad_oe_nxt, devsel_nxt, trdy_nxt, stop_nxt;
    logic           mem_we;
    logic [31:0]    mem_wdata;
    logic [31:0]    mem [DEPTH];
    logic           is_read, is_write, phase_done, addr_is_base;

    assign is_read    = (cmd == CMD_MEM_READ);
    assign is_write   = (cmd == CMD_MEM_WRITE);
    assign phase_done = !irdy && !TRDY;
    assign idx_inc    = idx + 1'b1;
    // The decoder owns address matching; a claimed transfer always starts at
    // word 0 whether or not the captured address equals the device base.
    assign addr_is_base = (addr == BASE_ADDR);

    // Byte-lane merge of write data into the current word (cbe is active low).
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be_n);
        logic [31:0] w;
        w = old_word;
        for (int k = 0; k < 4; k++) begin
            if (!be_n[k]) w[8*k +: 8] = new_word[8*k +: 8];
        end
        return w;
    endfunction

    // Next-state and next-output decode for the transfer FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        addr_nxt   = addr;
        cmd_nxt    = cmd;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        ad_out_nxt = ad_out;
        ad_oe_nxt  = ad_oe;
        devsel_nxt = DEVSEL;
        trdy_nxt   = TRDY;
        stop_nxt   = STOP;
        mem_we     = 1'b0;
        mem_wdata  = merge_lanes(mem[idx], AD, cbe);

        case (state)
            IDLE: begin
                if (!frame) begin
                    addr_nxt  = AD;
                    cmd_nxt   = cbe;
                    cnt_nxt   = '0;
                    state_nxt = CLAIM;
                end
            end

            CLAIM: begin
                // A decoder claim on the same edge as FRAME# release still wins.
                if (!dec_devsel) begin
                    if (is_read || is_write) begin
                        state_nxt  = DATA;
                        idx_nxt    = '0;
                        devsel_nxt = 1'b0;
                        trdy_nxt   = 1'b0;
                        if (is_read) begin
                            ad_oe_nxt  = 1'b1;
                            ad_out_nxt = mem[0];
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (frame || cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            DATA: begin
                if (phase_done) begin
                    mem_we = is_write;
                    if (idx != IDX_LAST) begin
                        idx_nxt = idx_inc;
                        if (is_read) ad_out_nxt = mem[idx_inc];
                    end
                    if (frame) begin
                        state_nxt  = TURN;
                        devsel_nxt = 1'b1;
                        trdy_nxt   = 1'b1;
                        stop_nxt   = 1'b1;
                        ad_oe_nxt  = 1'b0;
                    end else if (idx == IDX_LAST) begin
                        state_nxt = DISC;
                        trdy_nxt  = 1'b1;
                        stop_nxt  = 1'b0;
                    end
                end
            end

            DISC: begin
                if (frame) begin
                    state_nxt  = TURN;
                    devsel_nxt = 1'b1;
                    trdy_nxt   = 1'b1;
                    stop_nxt   = 1'b1;
                    ad_oe_nxt  = 1'b0;
                end
            end

            TURN: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt  = IDLE;
                devsel_nxt = 1'b1;
                trdy_nxt   = 1'b1;
                stop_nxt   = 1'b1;
                ad_oe_nxt  = 1'b0;
            end
        endcase
    end

    // State and bus-output registers, falling-edge clocked.
    always_ff @(negedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state  <= IDLE;
            addr   <= '0;
            cmd    <= '0;
            cnt    <= '0;
            idx    <= '0;
            ad_out <= '0;
            ad_oe  <= 1'b0;
            DEVSEL <= 1'b1;
            TRDY   <= 1'b1;
            STOP   <= 1'b1;
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            cmd    <= cmd_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            ad_out <= ad_out_nxt;
            ad_oe  <= ad_oe_nxt;
            DEVSEL <= devsel_nxt;
            TRDY   <= trdy_nxt;
            STOP   <= stop_nxt;
        end
    end

    // Local register file with byte-masked writes.
    always_ff @(negedge clk or negedge rst_n) begin
        // NOTE: the register file is architecturally cleared by reset, so it
        // is built from flops with an async clear rather than a RAM macro.
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[idx] <= mem_wdata;
        end
    end

    // The captured address is kept for debug visibility only.
    logic unused_addr;
    assign unused_addr = addr_is_base;

endmodule

// File: tb/tb_pci_target_data_phase.sv
// Directed bench for pci_target_data_phase: writes, byte masks, burst reads
// with a wait state, overrun disconnect, unclaimed/illegal cycles and reset.
module tb_pci_target_data_phase;

    logic        clk = 1'b1;
    logic        rst_n;
    logic        frame, irdy, dec_devsel;
    logic [31:0] AD;
    logic [3:0]  cbe;
    logic [31:0] ad_out;
    logic        ad_oe, DEVSEL, TRDY, STOP;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [16];

    // Expected {DEVSEL, TRDY, STOP, ad_oe}
    localparam logic [3:0] O_IDLE = 4'b1110;
    localparam logic [3:0] O_WR   = 4'b0010;
    localparam logic [3:0] O_RD   = 4'b0011;
    localparam logic [3:0] O_DISC = 4'b0100;

    pci_target_data_phase #(.BASE_ADDR(32'd1000), .DEPTH(16), .CLAIM_TO(4)) dut (
        .clk(clk), .rst_n(rst_n), .frame(frame), .irdy(irdy), .AD(AD), .cbe(cbe),
        .dec_devsel(dec_devsel), .ad_out(ad_out), .ad_oe(ad_oe),
        .DEVSEL(DEVSEL), .TRDY(TRDY), .STOP(STOP)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic i, input logic d,
                         input logic [31:0] a, input logic [3:0] c);
        frame = f; irdy = i; dec_devsel = d; AD = a; cbe = c;
    endtask

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] be_n);
        if (!be_n[0]) model[idx][7:0]   = d[7:0];
        if (!be_n[1]) model[idx][15:8]  = d[15:8];
        if (!be_n[2]) model[idx][23:16] = d[23:16];
        if (!be_n[3]) model[idx][31:24] = d[31:24];
    endtask

    // Write burst of n phases starting at word 0, frame released on the last.
    task automatic write_burst(input int n, input logic [31:0] base,
                               input logic [31:0] step, input logic [3:0] be_n,
                               input string tag);
        logic [3:0]  want;
        logic [31:0] d;
        drive(0, 1, 1, 32'd1000, 4'b0111);
        tick();
        total++;
        if ({DEVSEL, TRDY, STOP, ad_oe} !== O_IDLE) begin
            bad++; $display("FAIL %s addr: ctl=%b want=%b", tag, {DEVSEL, TRDY, STOP, ad_oe}, O_IDLE);
        end
        drive(0, 1, 0, 32'h0, 4'b0000);
        tick();
        total++;
        if ({DEVSEL, TRDY, STOP, ad_oe} !== O_WR) begin
            bad++; $display("FAIL %s claim: ctl=%b want=%b", tag, {DEVSEL, TRDY, STOP, ad_oe}, O_WR);
        end
        for (int i = 0; i < n; i++) begin
            d = base + step * i;
            drive((i == n - 1), 0, 1, d, be_n);
            tick();
            model_write(i, d, be_n);
            want = (i == n - 1) ? O_IDLE : O_WR;
            total++;
            if ({DEVSEL, TRDY, STOP, ad_oe} !== want) begin
                bad++; $display("FAIL %s phase%0d: ctl=%b want=%b", tag, i, {DEVSEL, TRDY, STOP, ad_oe}, want);
            end
        end
        drive(1, 1, 1, 32'h0, 4'b0000);
        tick();
        total++;
        if ({DEVSEL, TRDY, STOP, ad_oe} !== O_IDLE) begin
            bad++; $display("FAIL %s idle: ctl=%b want=%b", tag, {DEVSEL, TRDY, STOP, ad_oe}, O_IDLE);
        end
    endtask

    // Read burst of n words from word 0; optional irdy-high wait before phase wait_ph.
    task automatic read_burst(input int n, input int wait_ph, input string tag);
        drive(0, 1, 1, 32'd1000, 4'b0110);
        tick();
        drive(0, 1, 0, 32'h0, 4'b0000);
        tick();
        total++;
        if ({DEVSEL, TRDY, STOP, ad_oe} !== O_RD || ad_out !== model[0]) begin
            bad++; $display("FAIL %s claim: ctl=%b data=%h want ctl=%b data=%h",
                            tag, {DEVSEL, TRDY, STOP, ad_oe}, ad_out, O_RD, model[0]);
        end
        for (int i = 0; i < n; i++) begin
            if (i == wait_ph) begin
                drive(0, 1, 1, 32'h0, 4'b0000);
                tick();
                total++;
                if ({DEVSEL, TRDY, STOP, ad_oe} !== O_RD || ad_out !== model[i]) begin
                    bad++; $display("FAIL %s wait%0d: ctl=%b data=%h want ctl=%b data=%h",
                                    tag, i, {DEVSEL, TRDY, STOP, ad_oe}, ad_out, O_RD, model[i]);
                end
            end
            drive((i == n - 1), 0, 1, 32'h0, 4'b0000);
            tick();
            total++;
            if (i == n - 1) begin
                if ({DEVSEL, TRDY, STOP, ad_oe} !== O_IDLE) begin
                    bad++; $display("FAIL %s last: ctl=%b want=%b", tag, {DEVSEL, TRDY, STOP, ad_oe}, O_IDLE);
                end
            end else if ({DEVSEL, TRDY, STOP, ad_oe} !== O_RD || ad_out !== model[i + 1]) begin
                bad++; $display("FAIL %s word%0d: ctl=%b data=%h want ctl=%b data=%h",
                                tag, i + 1, {DEVSEL, TRDY, STOP, ad_oe}, ad_out, O_RD, model[i + 1]);
            end
        end
        drive(1, 1, 1, 32'h0, 4'b0000);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1, 1, 32'h0, 4'b0000);
        for (int i = 0; i < 16; i++) model[i] = '0;
        #12;
        total++;
        if ({DEVSEL, TRDY, STOP, ad_oe} !== O_IDLE || ad_out !== 32'h0) begin
            bad++; $display("FAIL reset: ctl=%b data=%h want ctl=%b data=0",
                            {DEVSEL, TRDY, STOP, ad_oe}, ad_out, O_IDLE);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_writes();
        write_burst(4, 32'hA0B0C0D0, 32'h01010101, 4'b0000, "burst_wr4");
        write_burst(1, 32'hDEADBEEF, 32'h0, 4'b0000, "single_wr");
        write_burst(1, 32'h11223344, 32'h0, 4'b1010, "masked_wr");
        total++;
        if (model[0] !== 32'hDE22BE44) begin
            bad++; $display("FAIL mask_model: got %h want DE22BE44", model[0]);
        end
    endtask

    task automatic test_burst_read();
        read_burst(4, 1, "rd4_wait");
    endtask

    task automatic test_overrun();
        logic [3:0]  want;
        logic [31:0] d;
        drive(0, 1, 1, 32'd1000, 4'b0111);
        tick();
        drive(0, 1, 0, 32'h0, 4'b0000);
        tick();
        for (int i = 0; i < 17; i++) begin
            d = 32'h10000000 + 32'h111 * i;
            drive(0, 0, 1, d, 4'b0000);
            tick();
            if (i < 16) model_write(i, d, 4'b0000);
            want = (i < 15) ? O_WR : O_DISC;
            total++;
            if ({DEVSEL, TRDY, STOP, ad_oe} !== want) begin
                bad++; $display("FAIL overrun phase%0d: ctl=%b want=%b", i, {DEVSEL, TRDY, STOP, ad_oe}, want);
            end
        end
        drive(0, 1, 1, 32'h0, 4'b0000);
        tick();
        total++;
        if ({DEVSEL, TRDY, STOP, ad_oe} !== O_DISC) begin
            bad++; $display("FAIL overrun hold: ctl=%b want=%b", {DEVSEL, TRDY, STOP, ad_oe}, O_DISC);
        end
        drive(1, 1, 1, 32'h0, 4'b0000);
        tick();
        total++;
        if ({DEVSEL, TRDY, STOP, ad_oe} !== O_IDLE) begin
            bad++; $display("FAIL overrun turn: ctl=%b want=%b", {DEVSEL, TRDY, STOP, ad_oe}, O_IDLE);
        end
        tick();
        // Full 16-word read: last phase at idx 15 with frame high goes to TURN.
        read_burst(16, -1, "rd16");
    endtask

    task automatic test_unclaimed();
        drive(0, 1, 1, 32'd1000, 4'b0111);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 32'h0, 4'b0000);
            tick();
            total++;
            if ({DEVSEL, TRDY, STOP, ad_oe} !== O_IDLE) begin
                bad++; $display("FAIL unclaimed edge%0d: ctl=%b want=%b", i, {DEVSEL, TRDY, STOP, ad_oe}, O_IDLE);
            end
        end
        // Late claim after the timeout must be ignored.
        drive(1, 0, 0, 32'hFFFFFFFF, 4'b0000);
        tick();
        total++;
        if ({DEVSEL, TRDY, STOP, ad_oe} !== O_IDLE) begin
            bad++; $display("FAIL late_claim: ctl=%b want=%b", {DEVSEL, TRDY, STOP, ad_oe}, O_IDLE);
        end
        drive(1, 1, 1, 32'h0, 4'b0000);
        tick();
    endtask

    task automatic test_illegal_cmd();
        drive(0, 1, 1, 32'd1000, 4'b0010);
        tick();
        drive(0, 1, 0, 32'h0, 4'b0000);
        tick();
        total++;
        if ({DEVSEL, TRDY, STOP, ad_oe} !== O_IDLE) begin
            bad++; $display("FAIL illegal claim: ctl=%b want=%b", {DEVSEL, TRDY, STOP, ad_oe}, O_IDLE);
        end
        drive(1, 0, 1, 32'hCAFEF00D, 4'b0000);
        tick();
        total++;
        if ({DEVSEL, TRDY, STOP, ad_oe} !== O_IDLE) begin
            bad++; $display("FAIL illegal data: ctl=%b want=%b", {DEVSEL, TRDY, STOP, ad_oe}, O_IDLE);
        end
        drive(1, 1, 1, 32'h0, 4'b0000);
        tick();
        read_burst(2, -1, "rd_after_illegal");
    endtask

    task automatic test_reset_mid_burst();
        drive(0, 1, 1, 32'd1000, 4'b0111);
        tick();
        drive(0, 1, 0, 32'h0, 4'b0000);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 32'h55AA0000 + i, 4'b0000);
            tick();
        end
        drive(0, 0, 1, 32'h77777777, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({DEVSEL, TRDY, STOP, ad_oe} !== O_IDLE || ad_out !== 32'h0) begin
            bad++; $display("FAIL mid_reset: ctl=%b data=%h want ctl=%b data=0",
                            {DEVSEL, TRDY, STOP, ad_oe}, ad_out, O_IDLE);
        end
        for (int i = 0; i < 16; i++) model[i] = '0;
        drive(1, 1, 1, 32'h0, 4'b0000);
        #1;
        rst_n = 1'b1;
        tick();
        read_burst(4, -1, "rd_after_reset");
        write_burst(2, 32'h0BADF00D, 32'h00000010, 4'b0000, "wr_after_reset");
        read_burst(3, -1, "rd_after_rewrite");
    endtask

    initial begin
        test_reset();
        test_writes();
        test_burst_read();
        test_overrun();
        test_unclaimed();
        test_illegal_cmd();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
